// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: parser states and frame byte codes.
package loader_pkg;

    // Parser states, one per frame field plus the two terminal states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TGT,
        ST_ADDR0,
        ST_ADDR1,
        ST_CNT0,
        ST_CNT1,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERR
    } loader_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] RUN_BYTE  = 8'h5A;
    localparam logic [7:0] TGT_IMEM  = 8'h00;
    localparam logic [7:0] TGT_DMEM  = 8'h01;

endpackage

// File: rtl/program_loader_if.sv
// Valid/ready byte stream feeding the program loader.
interface program_loader_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/program_loader_byte_packer.sv
// Packs four consecutive bytes into a little-endian 32-bit word and flags
// the completed word for exactly one cycle.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_idx;
    logic [23:0] partial;

    // Collect bytes into the low three lanes; the fourth byte completes the word
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx   <= 2'd0;
            partial    <= 24'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_idx <= 2'd0;
                partial  <= 24'd0;
            end else if (in_valid) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: partial[7:0]   <= in_byte;
                    2'd1: partial[15:8]  <= in_byte;
                    2'd2: partial[23:16] <= in_byte;
                    default: begin
                        word       <= {in_byte, partial};
                        word_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Byte-stream boot loader: parses load frames, writes IMEM/DMEM words and
// holds the CPU in reset until a RUN byte arrives.
module program_loader
    import loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024,
    localparam int IAW = $clog2(IMEM_DEPTH),
    localparam int DAW = $clog2(DMEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    program_loader_if.slave       stream,
    output logic                  imem_we,
    output logic [IAW-1:0]        imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  dmem_we,
    output logic [DAW-1:0]        dmem_addr,
    output logic [31:0]           dmem_wdata,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           words_written
);

    loader_state_e state;
    logic          tgt_dmem;
    logic [15:0]   addr;
    logic [7:0]    cnt_lo;
    logic [15:0]   words_left;
    logic [1:0]    byte_cnt;
    logic [7:0]    xor_acc;
    logic          accept;
    logic          pk_clear;
    logic          pk_in_valid;
    logic [31:0]   pk_word;
    logic          pk_valid;
    logic          unused_addr;

    assign stream.s_ready = (state != ST_RUN);
    assign accept         = stream.s_valid && stream.s_ready;
    assign pk_clear       = accept && (state == ST_IDLE) && (stream.s_data == SYNC_BYTE);
    assign pk_in_valid    = accept && (state == ST_DATA);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .in_byte    (stream.s_data),
        .in_valid   (pk_in_valid),
        .clear      (pk_clear),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    // The address register is 16 bits wide so that truncation to each
    // memory's width gives modulo-depth wrap for free; upper bits are spare.
    assign unused_addr = ^addr;

    assign imem_we    = pk_valid && !tgt_dmem;
    assign dmem_we    = pk_valid && tgt_dmem;
    assign imem_addr  = addr[IAW-1:0];
    assign dmem_addr  = addr[DAW-1:0];
    assign imem_wdata = pk_word;
    assign dmem_wdata = pk_word;
    assign busy       = (state != ST_IDLE) && (state != ST_RUN) && (state != ST_ERR);

    // Frame parser, address/word bookkeeping and sticky status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            tgt_dmem      <= 1'b0;
            addr          <= 16'd0;
            cnt_lo        <= 8'd0;
            words_left    <= 16'd0;
            byte_cnt      <= 2'd0;
            xor_acc       <= 8'd0;
            cpu_rst_n     <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            words_written <= 16'd0;
        end else begin
            if (pk_valid) begin
                addr <= addr + 16'd1;
                if (words_written != 16'hFFFF) begin
                    words_written <= words_written + 16'd1;
                end
            end
            if (accept) begin
                case (state)
                    ST_IDLE: begin
                        if (stream.s_data == SYNC_BYTE) begin
                            state   <= ST_TGT;
                            xor_acc <= 8'd0;
                        end else if (stream.s_data == RUN_BYTE) begin
                            state     <= ST_RUN;
                            cpu_rst_n <= 1'b1;
                            done      <= 1'b1;
                        end
                    end
                    ST_TGT: begin
                        if (stream.s_data == TGT_IMEM) begin
                            tgt_dmem <= 1'b0;
                            state    <= ST_ADDR0;
                        end else if (stream.s_data == TGT_DMEM) begin
                            tgt_dmem <= 1'b1;
                            state    <= ST_ADDR0;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                    ST_ADDR0: begin
                        addr[7:0] <= stream.s_data;
                        state     <= ST_ADDR1;
                    end
                    ST_ADDR1: begin
                        addr[15:8] <= stream.s_data;
                        state      <= ST_CNT0;
                    end
                    ST_CNT0: begin
                        cnt_lo <= stream.s_data;
                        state  <= ST_CNT1;
                    end
                    ST_CNT1: begin
                        words_left <= {stream.s_data, cnt_lo};
                        byte_cnt   <= 2'd0;
                        if ({stream.s_data, cnt_lo} == 16'd0) begin
                            state <= ST_CSUM;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        xor_acc  <= xor_acc ^ stream.s_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            words_left <= words_left - 16'd1;
                            if (words_left == 16'd1) begin
                                state <= ST_CSUM;
                            end
                        end
                    end
                    ST_CSUM: begin
                        if (stream.s_data == xor_acc) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: frames are described at field level,
// expected memory writes are queued, and a monitor checks every strobe.
module tb_program_loader;
    import loader_pkg::*;

    localparam int IMEM_DEPTH = 1024;
    localparam int DMEM_DEPTH = 1024;

    typedef struct {
        bit          is_dmem;
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_we, dmem_we, cpu_rst_n, busy, done, err;
    logic [9:0]  imem_addr, dmem_addr;
    logic [31:0] imem_wdata, dmem_wdata;
    logic [15:0] words_written;

    program_loader_if bus ();

    program_loader #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .stream        (bus),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .cpu_rst_n     (cpu_rst_n),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  passes = 0;
    bit  model_err;
    bit  model_run;
    int  model_words;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Offer one byte after an optional idle gap; returns just after the accepting edge
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            bus.s_valid = 1'b0;
        end
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        n = 0;
        while (!bus.s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) begin
            checkOutput("ready_timeout", bus.s_ready, 1);
            bus.s_valid = 1'b0;
            return;
        end
        @(posedge clk);
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        @(negedge clk);
        exp_q.delete();
        model_err   = 1'b0;
        model_run   = 1'b0;
        model_words = 0;
        rst = 1'b0;
    endtask

    // Reference: a good frame writes word i to (addr + i) mod depth unless the loader is stopped
    task automatic send_frame(input bit is_dmem, input logic [15:0] addr,
                              input logic [31:0] words[$], input int csum_mode, input int max_gap);
        logic [31:0] fold;
        logic [7:0]  good, cs;
        int          depth;
        fold = 32'd0;
        foreach (words[i]) fold ^= words[i];
        good  = fold[7:0] ^ fold[15:8] ^ fold[23:16] ^ fold[31:24];
        cs    = (csum_mode < 0) ? good : 8'(csum_mode);
        depth = is_dmem ? DMEM_DEPTH : IMEM_DEPTH;
        if (!model_err && !model_run) begin
            foreach (words[i]) begin
                exp_q.push_back('{is_dmem, (int'(addr) + i) % depth, words[i]});
                model_words++;
            end
        end
        applyStimulus(SYNC_BYTE, $urandom_range(0, max_gap));
        applyStimulus(is_dmem ? TGT_DMEM : TGT_IMEM, $urandom_range(0, max_gap));
        applyStimulus(addr[7:0], $urandom_range(0, max_gap));
        applyStimulus(addr[15:8], $urandom_range(0, max_gap));
        applyStimulus(8'(words.size()), $urandom_range(0, max_gap));
        applyStimulus(8'(words.size() >> 8), $urandom_range(0, max_gap));
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) begin
                applyStimulus(words[i][8*k +: 8], $urandom_range(0, max_gap));
            end
        end
        applyStimulus(cs, $urandom_range(0, max_gap));
        if (cs != good && !model_run) model_err = 1'b1;
        go_idle();
    endtask

    task automatic check_status(input string tag);
        repeat (4) @(negedge clk);
        checkOutput({tag, "_pending"}, exp_q.size(), 0);
        checkOutput({tag, "_words_written"}, words_written, 16'(model_words));
        checkOutput({tag, "_err"}, err, model_err);
        checkOutput({tag, "_done"}, done, model_run);
        checkOutput({tag, "_cpu_rst_n"}, cpu_rst_n, model_run);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && (imem_we || dmem_we)) begin
            checkOutput("single_we", {31'd0, imem_we && dmem_we}, 0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("write_target", {31'd0, dmem_we}, {31'd0, mon_e.is_dmem});
                checkOutput("write_addr", dmem_we ? {22'd0, dmem_addr} : {22'd0, imem_addr}, mon_e.addr);
                checkOutput("write_data", dmem_we ? dmem_wdata : imem_wdata, mon_e.data);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w[$];
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("reset_imem_we", imem_we, 0);
        checkOutput("reset_dmem_we", dmem_we, 0);
        checkOutput("reset_cpu_rst_n", cpu_rst_n, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_words", words_written, 0);
        checkOutput("reset_addr", imem_addr, 0);
        checkOutput("reset_wdata", imem_wdata, 0);
        checkOutput("reset_s_ready", bus.s_ready, 1);
        do_reset();

        $display("[TB] basic IMEM frame");
        w = '{32'h44332211, 32'h88776655};
        send_frame(1'b0, 16'h0010, w, -1, 0);
        check_status("imem_basic");

        $display("[TB] DMEM frame with address wrap");
        do_reset();
        w = '{32'hDEADBEEF, 32'h00000001};
        send_frame(1'b1, 16'h03FF, w, -1, 1);
        check_status("dmem_wrap");

        $display("[TB] randomized frames");
        do_reset();
        for (int f = 0; f < 25; f++) begin
            w.delete();
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) w.push_back($urandom);
            send_frame(1'($urandom), ($urandom_range(0, 3) == 0) ? 16'(16'h03FE + $urandom_range(0, 1)) : 16'($urandom),
                       w, -1, 2);
        end
        check_status("random");

        $display("[TB] checksum mismatch");
        do_reset();
        w = '{32'h44332211, 32'h88776655};
        send_frame(1'b0, 16'h0010, w, 8'h00, 0);
        check_status("bad_csum");
        checkOutput("bad_csum_s_ready", bus.s_ready, 1);
        applyStimulus(RUN_BYTE, 0);
        go_idle();
        check_status("bad_csum_run_ignored");

        $display("[TB] illegal target");
        do_reset();
        applyStimulus(SYNC_BYTE, 0);
        applyStimulus(8'h07, 0);
        model_err = 1'b1;
        w = '{32'h11111111};
        send_frame(1'b0, 16'h0000, w, -1, 0);
        check_status("bad_tgt");

        $display("[TB] empty frame then RUN");
        do_reset();
        w.delete();
        send_frame(1'b0, 16'h0123, w, 8'h00, 0);
        check_status("cnt0");
        applyStimulus(RUN_BYTE, 0);
        go_idle();
        model_run = 1'b1;
        checkOutput("run_cpu_rst_n", cpu_rst_n, 1);
        checkOutput("run_done", done, 1);
        checkOutput("run_s_ready", bus.s_ready, 0);
        check_status("run");

        $display("[TB] reset mid-frame");
        do_reset();
        applyStimulus(SYNC_BYTE, 0);
        applyStimulus(TGT_IMEM, 0);
        applyStimulus(8'h20, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'hAA, 0);
        applyStimulus(8'hBB, 0);
        do_reset();
        checkOutput("abort_busy", busy, 0);
        w = '{32'hCAFEF00D, 32'h12345678, 32'h0BADC0DE};
        send_frame(1'b0, 16'h0040, w, -1, 1);
        check_status("after_abort");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
